// File: rtl/sram_lsu_bridge_if.sv
// LSU-side and SRAM-controller-side bundles for the sram_lsu_bridge.
// Signal names keep the core/controller port names so waveforms line up with the neighbours.
interface lsu_port_if;
  logic [31:0] i_lsu_addr;
  logic [31:0] i_lsu_wdata;
  logic [1:0]  i_lsu_size;
  logic        i_lsu_unsigned;
  logic        i_lsu_wren;
  logic        i_lsu_rden;
  logic [31:0] o_lsu_rdata;
  logic        o_lsu_stall;
  logic        o_lsu_done;
  logic        o_lsu_misaligned;
  logic        o_lsu_err;

  modport master (
    output i_lsu_addr, i_lsu_wdata, i_lsu_size, i_lsu_unsigned, i_lsu_wren, i_lsu_rden,
    input  o_lsu_rdata, o_lsu_stall, o_lsu_done, o_lsu_misaligned, o_lsu_err
  );
  modport slave (
    input  i_lsu_addr, i_lsu_wdata, i_lsu_size, i_lsu_unsigned, i_lsu_wren, i_lsu_rden,
    output o_lsu_rdata, o_lsu_stall, o_lsu_done, o_lsu_misaligned, o_lsu_err
  );
endinterface

interface sram_port_if;
  logic [17:0] o_ADDR;
  logic [31:0] o_WDATA;
  logic [3:0]  o_BMASK;
  logic        o_WREN;
  logic        o_RDEN;
  logic [31:0] i_RDATA;
  logic        i_ACK;

  modport master (
    output o_ADDR, o_WDATA, o_BMASK, o_WREN, o_RDEN,
    input  i_RDATA, i_ACK
  );
  modport slave (
    input  o_ADDR, o_WDATA, o_BMASK, o_WREN, o_RDEN,
    output i_RDATA, i_ACK
  );
endinterface

// File: rtl/sram_lsu_bridge.sv
// Turns one LSU byte/half/word access into a single 32-bit SRAM controller transaction,
// stalling the core until the controller acks or the wait times out.
//
//  state | meaning
//  IDLE  | waiting for an aligned request; captures it and raises stall
//  ISSUE | one-cycle WREN/RDEN strobe to the controller
//  WAIT  | strobes low, counting cycles until ACK or TIMEOUT
//  DONE  | done pulse; core advances, request still on the bus is ignored
module sram_lsu_bridge #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        i_clk,
  input  logic        i_reset,
  lsu_port_if.slave   lsu,
  sram_port_if.master sram
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [7:0] TIMEOUT_TC = 8'(TIMEOUT - 1);

  state_t      state;
  state_t      state_nxt;
  logic        req;
  logic        bad_align;
  logic        accept;
  logic        capture;
  logic        ack_take;
  logic        timeout;
  logic [3:0]  st_bmask;
  logic [31:0] st_wdata;
  logic        cap_wr;
  logic        cap_uns;
  logic [1:0]  cap_size;
  logic [1:0]  cap_lane;
  logic [7:0]  wait_cnt;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] rd_ext;
  logic        unused_addr_hi;

  assign unused_addr_hi = ^lsu.i_lsu_addr[31:19];

  assign req       = lsu.i_lsu_wren ^ lsu.i_lsu_rden;
  assign bad_align = (lsu.i_lsu_size == 2'b11) ||
                     (lsu.i_lsu_size == 2'b01 && lsu.i_lsu_addr[0]) ||
                     (lsu.i_lsu_size == 2'b10 && lsu.i_lsu_addr[1:0] != 2'b00);
  assign accept    = req && !bad_align;

  assign lsu.o_lsu_misaligned = req && bad_align;
  assign lsu.o_lsu_stall      = i_reset &&
                                ((state == ST_IDLE && accept) || state == ST_ISSUE || state == ST_WAIT);

  always_comb begin
    st_bmask = 4'b1111;
    st_wdata = lsu.i_lsu_wdata;
    case (lsu.i_lsu_size)
      2'b00: begin
        st_bmask = 4'b0001 << lsu.i_lsu_addr[1:0];
        st_wdata = {4{lsu.i_lsu_wdata[7:0]}};
      end
      2'b01: begin
        st_bmask = lsu.i_lsu_addr[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{lsu.i_lsu_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  // Lane selection uses the address captured at request time, not the live bus.
  always_comb begin
    rd_byte = sram.i_RDATA[{cap_lane, 3'b000} +: 8];
    rd_half = cap_lane[1] ? sram.i_RDATA[31:16] : sram.i_RDATA[15:0];
    case (cap_size)
      2'b00:   rd_ext = {{24{~cap_uns & rd_byte[7]}}, rd_byte};
      2'b01:   rd_ext = {{16{~cap_uns & rd_half[15]}}, rd_half};
      default: rd_ext = sram.i_RDATA;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ACK wins over the timeout on the last allowed WAIT cycle.
  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    ack_take  = 1'b0;
    timeout   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          capture   = 1'b1;
          state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (sram.i_ACK) begin
          ack_take  = 1'b1;
          state_nxt = ST_DONE;
        end else if (wait_cnt == TIMEOUT_TC) begin
          timeout   = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      sram.o_ADDR     <= '0;
      sram.o_WDATA    <= '0;
      sram.o_BMASK    <= '0;
      sram.o_WREN     <= 1'b0;
      sram.o_RDEN     <= 1'b0;
      lsu.o_lsu_rdata <= '0;
      lsu.o_lsu_done  <= 1'b0;
      lsu.o_lsu_err   <= 1'b0;
      cap_wr          <= 1'b0;
      cap_uns         <= 1'b0;
      cap_size        <= 2'b00;
      cap_lane        <= 2'b00;
      wait_cnt        <= '0;
    end else begin
      sram.o_WREN    <= capture && lsu.i_lsu_wren;
      sram.o_RDEN    <= capture && lsu.i_lsu_rden;
      lsu.o_lsu_done <= ack_take;
      lsu.o_lsu_err  <= timeout;
      if (capture) begin
        sram.o_ADDR  <= {lsu.i_lsu_addr[18:2], 1'b0};
        sram.o_BMASK <= lsu.i_lsu_wren ? st_bmask : 4'b1111;
        sram.o_WDATA <= lsu.i_lsu_wren ? st_wdata : 32'h0;
        cap_wr       <= lsu.i_lsu_wren;
        cap_uns      <= lsu.i_lsu_unsigned;
        cap_size     <= lsu.i_lsu_size;
        cap_lane     <= lsu.i_lsu_addr[1:0];
      end
      if (ack_take && !cap_wr) begin
        lsu.o_lsu_rdata <= rd_ext;
      end
      if (state == ST_WAIT && state_nxt == ST_WAIT) begin
        wait_cnt <= wait_cnt + 8'd1;
      end else begin
        wait_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_sram_lsu_bridge.sv
// Bench for sram_lsu_bridge: directed cases plus random loads/stores against a
// byte-addressed memory model, with a simple controller model answering the SRAM side.
module tb_sram_lsu_bridge;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  lsu_port_if  lsu ();
  sram_port_if sram ();

  sram_lsu_bridge #(.TIMEOUT(16)) dut (
    .i_clk   (clk),
    .i_reset (rst_n),
    .lsu     (lsu.slave),
    .sram    (sram.master)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // controller model: word store with byte mask, ack ctl_dly cycles after the strobe
  int         gcyc = 0;
  bit [31:0]  ctl_mem [int];
  bit         ctl_pend = 0;
  bit         ctl_mute = 0;
  bit         force_ack = 0;
  int         ctl_ack_cyc = 0;
  int         ctl_idx = 0;
  int         ctl_dly = 2;
  int         wren_pulses = 0;
  int         rden_pulses = 0;

  initial forever begin
    @(posedge clk);
    gcyc++;
  end

  initial forever begin
    bit [31:0] w;
    @(negedge clk);
    if (!rst_n) begin
      ctl_pend = 0;
    end else if (sram.o_WREN || sram.o_RDEN) begin
      if (sram.o_WREN) wren_pulses++;
      if (sram.o_RDEN) rden_pulses++;
      ctl_idx = int'(sram.o_ADDR[17:1]);
      if (sram.o_WREN) begin
        w = ctl_mem.exists(ctl_idx) ? ctl_mem[ctl_idx] : 32'h0;
        for (int k = 0; k < 4; k++)
          if (sram.o_BMASK[k]) w[8*k +: 8] = sram.o_WDATA[8*k +: 8];
        ctl_mem[ctl_idx] = w;
      end
      if (!ctl_mute) begin
        ctl_pend    = 1;
        ctl_ack_cyc = gcyc + ctl_dly;
      end
    end
  end

  initial begin
    sram.i_ACK   = 1'b0;
    sram.i_RDATA = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      if (ctl_pend && gcyc == ctl_ack_cyc) begin
        sram.i_ACK   = 1'b1;
        sram.i_RDATA = ctl_mem.exists(ctl_idx) ? ctl_mem[ctl_idx] : 32'h0;
        ctl_pend     = 0;
      end else begin
        sram.i_ACK   = force_ack;
        sram.i_RDATA = $urandom;
      end
    end
  end

  // reference: plain byte-addressed memory
  bit [7:0]  ref_mem [int];
  bit [31:0] last_rdata = 0;

  function automatic bit [7:0] ref_byte(input int a);
    return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
  endfunction

  function automatic bit [31:0] ref_load(input bit [31:0] a, input bit [1:0] sz, input bit uns);
    int n = 1 << sz;
    bit [31:0] v = 0;
    for (int i = 0; i < n; i++) v = v | (32'(ref_byte(int'(a) + i)) << (8 * i));
    if (!uns && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
    return v;
  endfunction

  function automatic void ref_store(input bit [31:0] a, input bit [1:0] sz, input bit [31:0] d);
    int n = 1 << sz;
    for (int i = 0; i < n; i++) ref_mem[int'(a) + i] = d[8*i +: 8];
  endfunction

  function automatic bit ref_bad(input bit [31:0] a, input bit [1:0] sz);
    if (sz == 2'd3) return 1;
    return (a % (32'd1 << sz)) != 0;
  endfunction

  logic [17:0] res_addr;
  logic [3:0]  res_mask;
  logic [31:0] res_wdata;
  logic [31:0] res_rdata;
  int          res_done;

  task automatic drop_req();
    lsu.i_lsu_wren = 1'b0;
    lsu.i_lsu_rden = 1'b0;
  endtask

  // Entered and left at posedge+1; cycle 0 is the cycle the request is presented.
  task automatic lsu_op(input bit wr, input bit rd, input bit [31:0] addr, input bit [31:0] wdata,
                        input bit [1:0] size, input bit uns, input int dly, input string tag);
    bit        req = wr ^ rd;
    bit        mis = req && ref_bad(addr, size);
    int        wp0 = wren_pulses;
    int        rp0 = rden_pulses;
    int        stall_cnt = 0;
    int        issue_cyc = -1;
    int        exp_done = 2 + dly;
    bit [31:0] exp_rd;
    bit [3:0]  exp_mask;
    bit [31:0] exp_wdata;
    ctl_dly = dly;
    lsu.i_lsu_addr     = addr;
    lsu.i_lsu_wdata    = wdata;
    lsu.i_lsu_size     = size;
    lsu.i_lsu_unsigned = uns;
    lsu.i_lsu_wren     = wr;
    lsu.i_lsu_rden     = rd;
    res_done = -1;
    if (!req || mis) begin
      for (int c = 0; c < 3; c++) begin
        @(negedge clk);
        if (c == 0) begin
          check({tag, " misaligned"}, lsu.o_lsu_misaligned, mis);
          check({tag, " no-stall"}, lsu.o_lsu_stall, 1'b0);
        end
        if (lsu.o_lsu_done) res_done = c;
        @(posedge clk);
        #1;
      end
      check({tag, " no-access"}, (wren_pulses - wp0) + (rden_pulses - rp0), 0);
      check({tag, " no-done"}, res_done, -1);
      drop_req();
      return;
    end
    exp_rd = wr ? last_rdata : ref_load(addr, size, uns);
    exp_mask  = 4'hF;
    exp_wdata = wdata;
    if (wr && size == 2'd0) begin
      exp_mask  = 4'b0001 << (addr % 4);
      exp_wdata = 32'(wdata[7:0]) * 32'h0101_0101;
    end else if (wr && size == 2'd1) begin
      exp_mask  = ((addr % 4) >= 2) ? 4'hC : 4'h3;
      exp_wdata = 32'(wdata[15:0]) * 32'h0001_0001;
    end
    for (int c = 0; c < 64; c++) begin
      @(negedge clk);
      if (lsu.o_lsu_stall) stall_cnt++;
      if (sram.o_WREN || sram.o_RDEN) begin
        issue_cyc = c;
        res_addr  = sram.o_ADDR;
        res_mask  = sram.o_BMASK;
        res_wdata = sram.o_WDATA;
      end
      if (lsu.o_lsu_done) begin
        res_done  = c;
        res_rdata = lsu.o_lsu_rdata;
        break;
      end
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1;
    drop_req();
    check({tag, " done-cycle"}, res_done, exp_done);
    check({tag, " stall-cycles"}, stall_cnt, exp_done);
    check({tag, " issue-cycle"}, issue_cyc, 1);
    check({tag, " wren-pulses"}, wren_pulses - wp0, wr ? 1 : 0);
    check({tag, " rden-pulses"}, rden_pulses - rp0, wr ? 0 : 1);
    check({tag, " addr"}, 32'(res_addr), (addr & 32'h0007_FFFC) >> 1);
    check({tag, " bmask"}, 32'(res_mask), 32'(exp_mask));
    if (wr) check({tag, " wdata"}, res_wdata, exp_wdata);
    check({tag, " rdata"}, res_rdata, exp_rd);
    if (wr) ref_store(addr, size, wdata);
    else last_rdata = exp_rd;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int err_cyc;
    int err_cnt;
    int stall_cnt;
    bit saw_done;
    lsu.i_lsu_addr     = 32'h0;
    lsu.i_lsu_wdata    = 32'h0;
    lsu.i_lsu_size     = 2'd2;
    lsu.i_lsu_unsigned = 1'b0;
    lsu.i_lsu_wren     = 1'b1;
    lsu.i_lsu_rden     = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset stall", lsu.o_lsu_stall, 1'b0);
    check("reset outputs", {14'h0, sram.o_ADDR} | sram.o_WDATA | 32'(sram.o_BMASK) |
          lsu.o_lsu_rdata, 32'h0);
    check("reset strobes", {sram.o_WREN, sram.o_RDEN, lsu.o_lsu_done, lsu.o_lsu_err}, 4'b0000);
    drop_req();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    lsu_op(1, 0, 32'h100, 32'hDEAD_BEEF, 2'd2, 0, 2, "t1 word store");
    check("t1 addr const", 32'(res_addr), 32'h080);
    check("t1 wdata const", res_wdata, 32'hDEAD_BEEF);
    check("t1 done const", res_done, 4);

    lsu_op(1, 0, 32'h206, 32'h0000_ABCD, 2'd1, 0, 2, "t2 half store");
    check("t2 addr const", 32'(res_addr), 32'h102);
    check("t2 mask const", 32'(res_mask), 32'hC);
    check("t2 wdata const", res_wdata, 32'hABCD_ABCD);

    lsu_op(1, 0, 32'h100, 32'h80FF_1234, 2'd2, 0, 2, "t3 setup");
    lsu_op(0, 1, 32'h103, 32'h0, 2'd0, 0, 3, "t3 byte load s");
    check("t3 signed const", res_rdata, 32'hFFFF_FF80);
    check("t3 done const", res_done, 5);
    lsu_op(0, 1, 32'h103, 32'h0, 2'd0, 1, 3, "t3 byte load u");
    check("t3 unsigned const", res_rdata, 32'h0000_0080);

    lsu_op(0, 1, 32'h102, 32'h0, 2'd2, 0, 3, "t4 word mis");
    lsu_op(0, 1, 32'h001, 32'h0, 2'd1, 0, 3, "t4 half mis");
    lsu_op(1, 0, 32'h004, 32'h1, 2'd3, 0, 3, "t4 size11");
    lsu_op(1, 1, 32'h100, 32'h0, 2'd2, 0, 3, "t6 both");

    lsu_op(0, 1, 32'h206, 32'h0, 2'd1, 0, 16, "ack last wait cycle");

    // ack pulses with no request must be ignored
    force_ack = 1;
    repeat (2) begin
      @(negedge clk);
      check("stray ack done", lsu.o_lsu_done, 1'b0);
      @(posedge clk);
      #1;
    end
    force_ack = 0;
    check("stray ack rdata", lsu.o_lsu_rdata, last_rdata);

    // t5: no ack -> timeout after 16 WAIT cycles
    ctl_mute = 1;
    lsu.i_lsu_addr = 32'h100;
    lsu.i_lsu_size = 2'd2;
    lsu.i_lsu_rden = 1'b1;
    err_cyc = -1;
    err_cnt = 0;
    stall_cnt = 0;
    saw_done = 0;
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      if (lsu.o_lsu_stall) stall_cnt++;
      if (lsu.o_lsu_done) saw_done = 1;
      if (lsu.o_lsu_err) begin
        err_cnt++;
        if (err_cyc < 0) err_cyc = c;
      end
      @(posedge clk);
      #1;
      if (c == 17) drop_req();
    end
    ctl_mute = 0;
    check("t5 err cycle", err_cyc, 18);
    check("t5 err width", err_cnt, 1);
    check("t5 stall cycles", stall_cnt, 18);
    check("t5 no done", saw_done, 1'b0);
    lsu_op(0, 1, 32'h100, 32'h0, 2'd2, 0, 3, "t5 after timeout");

    // t6: reset while in WAIT
    ctl_mute = 1;
    lsu.i_lsu_addr = 32'h104;
    lsu.i_lsu_size = 2'd2;
    lsu.i_lsu_rden = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    drop_req();
    @(posedge clk);
    #1;
    @(negedge clk);
    check("t6 rst outputs", {14'h0, sram.o_ADDR} | sram.o_WDATA | 32'(sram.o_BMASK) |
          lsu.o_lsu_rdata, 32'h0);
    check("t6 rst strobes", {sram.o_WREN, sram.o_RDEN, lsu.o_lsu_done, lsu.o_lsu_err,
          lsu.o_lsu_stall}, 5'b00000);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    ctl_mute = 0;
    last_rdata = 0;
    lsu_op(0, 1, 32'h100, 32'h0, 2'd2, 0, 3, "t6 load after reset");

    for (int i = 0; i < 60; i++) begin
      bit        wr = 1'($urandom_range(0, 1));
      bit        both = ($urandom_range(0, 15) == 0);
      bit [1:0]  sz = 2'($urandom_range(0, 2));
      bit [31:0] a = 32'($urandom_range(0, 63));
      if ($urandom_range(0, 7) == 0) sz = 2'd3;
      else if ($urandom_range(0, 7) != 0) a = a & ~((32'd1 << sz) - 1);
      lsu_op(wr | both, ~wr | both, a | (32'($urandom_range(0, 1)) << 20), $urandom, sz,
             1'($urandom_range(0, 1)), $urandom_range(1, 6), "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
